top_fwd: RTL and testbench

Forward (alpha) recursion engine of the max-log-MAP decoder for the 8-state recursive systematic constituent code. For each trellis step it reads the systematic and parity LLRs of the step from the input buffer. It writes the current alpha vector to the alpha memory, then computes the next alpha vector with add-compare-select and normalisation. It is the counterpart of the backward (beta) unit and runs over the same block length `count_main`; the LLR stage combines the stored alphas with the betas.

---
 rtl/top_fwd.sv | 136 +++++++++++++
 tb/tb_top_fwd.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/top_fwd.sv
// Forward (alpha) recursion of the max-log-MAP decoder for the 8-state RSC code.
// Two cycles per trellis step: RD issues the LLR read and writes alpha_k, CMP runs ACS.
module top_fwd (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [7:0]         count_main,
    input  logic signed [15:0] lsys,
    input  logic signed [15:0] lpar,
    output logic [7:0]         rd_addr,
    output logic [7:0]         fa_addr,
    output logic               w_r_f,
    output logic signed [15:0] a0,
    output logic signed [15:0] a1,
    output logic signed [15:0] a2,
    output logic signed [15:0] a3,
    output logic signed [15:0] a4,
    output logic signed [15:0] a5,
    output logic signed [15:0] a6,
    output logic signed [15:0] a7,
    output logic               busy,
    output logic               done_fwd
);

    localparam int DATA_W = 16;
    localparam logic signed [DATA_W-1:0] NEG = -16'sd16384;

    typedef enum logic [1:0] {IDLE, RD, CMP, DONE} state_t;

    state_t state, state_nxt;
    logic [7:0] k, k_inc, n_blk;
    logic accept;

    logic signed [DATA_W-1:0] alpha     [8];
    logic signed [DATA_W-1:0] alpha_nxt [8];
    logic signed [17:0]       acs_new   [8];
    logic signed [17:0]       mx;

    function automatic logic signed [16:0] branch(input logic u, input logic p,
                                                  input logic signed [15:0] ls,
                                                  input logic signed [15:0] lp);
        logic signed [16:0] g;
        g = '0;
        if (u) g = g + {ls[15], ls};
        if (p) g = g + {lp[15], lp};
        return g;
    endfunction

    function automatic logic signed [17:0] add_metric(input logic signed [15:0] a,
                                                      input logic signed [16:0] g);
        logic signed [17:0] c;
        c = {{2{a[15]}}, a} + {g[16], g};
        return c;
    endfunction

    // Normalised value is always <= 0, so only the negative rail needs clamping.
    function automatic logic signed [15:0] sat_norm(input logic signed [17:0] v,
                                                    input logic signed [17:0] m);
        logic signed [18:0] d;
        d = {v[17], v} - {m[17], m};
        if (d < -19'sd32768) return -16'sd32768;
        return d[15:0];
    endfunction

    assign accept = start && (state == IDLE || state == DONE);
    assign k_inc  = k + 8'd1;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (start) state_nxt = (count_main == 8'd0) ? DONE : RD;
            RD:         state_nxt = CMP;
            CMP:        state_nxt = (k_inc == n_blk) ? DONE : RD;
            default:    state_nxt = IDLE;
        endcase
    end

    // Predecessors of next state n are {n[1], n[0], d3}; u and p follow from the feedback bit n[2].
    for (genvar g = 0; g < 8; g++) begin : g_acs
        localparam logic [2:0] S  = 3'(g);
        localparam logic [2:0] P0 = {S[1:0], 1'b0};
        localparam logic [2:0] P1 = {S[1:0], 1'b1};
        logic signed [17:0] c0, c1;
        assign c0 = add_metric(alpha[P0], branch(S[2] ^ S[0], S[2] ^ S[1], lsys, lpar));
        assign c1 = add_metric(alpha[P1], branch(~(S[2] ^ S[0]), ~(S[2] ^ S[1]), lsys, lpar));
        assign acs_new[g] = (c1 > c0) ? c1 : c0;
    end

    always_comb begin
        mx = acs_new[0];
        for (int i = 1; i < 8; i++)
            if (acs_new[i] > mx) mx = acs_new[i];
        for (int i = 0; i < 8; i++)
            alpha_nxt[i] = sat_norm(acs_new[i], mx);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            k       <= '0;
            n_blk   <= '0;
            rd_addr <= '0;
            fa_addr <= '0;
            for (int i = 0; i < 8; i++) alpha[i] <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                n_blk    <= count_main;
                k        <= '0;
                alpha[0] <= '0;
                for (int i = 1; i < 8; i++) alpha[i] <= NEG;
            end else if (state == CMP) begin
                k <= k_inc;
                for (int i = 0; i < 8; i++) alpha[i] <= alpha_nxt[i];
            end
            if (state_nxt == RD) begin
                rd_addr <= (state == CMP) ? k_inc : 8'd0;
                fa_addr <= (state == CMP) ? k_inc : 8'd0;
            end
        end
    end

    assign w_r_f    = (state == RD);
    assign busy     = (state == RD) || (state == CMP);
    assign done_fwd = (state == DONE);

    assign a0 = alpha[0];
    assign a1 = alpha[1];
    assign a2 = alpha[2];
    assign a3 = alpha[3];
    assign a4 = alpha[4];
    assign a5 = alpha[5];
    assign a6 = alpha[6];
    assign a7 = alpha[7];

endmodule

// File: tb/tb_top_fwd.sv
// Bench for top_fwd: LLR buffer model, forward-trellis reference model and write scoreboard.
module tb_top_fwd;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [7:0]         count_main;
    logic signed [15:0] lsys, lpar;
    logic [7:0]         rd_addr, fa_addr;
    logic               w_r_f, busy, done_fwd;
    logic signed [15:0] a0, a1, a2, a3, a4, a5, a6, a7;

    top_fwd dut (
        .clk(clk), .rst(rst), .start(start), .count_main(count_main),
        .lsys(lsys), .lpar(lpar), .rd_addr(rd_addr), .fa_addr(fa_addr),
        .w_r_f(w_r_f), .a0(a0), .a1(a1), .a2(a2), .a3(a3), .a4(a4),
        .a5(a5), .a6(a6), .a7(a7), .busy(busy), .done_fwd(done_fwd)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]       addr;
        logic [7:0][15:0] v;
    } exp_t;

    exp_t exp_q[$];
    int   chk_cnt  = 0;
    int   pass_cnt = 0;
    int   m_alpha[8];
    logic signed [15:0] sys_mem[256];
    logic signed [15:0] par_mem[256];
    logic [7:0][15:0]   got;

    assign got = {a7, a6, a5, a4, a3, a2, a1, a0};

    // LLR buffer with one cycle of read latency
    always @(posedge clk) begin
        lsys <= sys_mem[rd_addr];
        lpar <= par_mem[rd_addr];
    end

    task automatic model_init();
        m_alpha[0] = 0;
        for (int i = 1; i < 8; i++) m_alpha[i] = -16384;
    endtask

    // Walks the trellis forwards from every source state and input bit.
    task automatic model_step(input int ls, input int lp);
        int nw[8];
        int mx, d1, d2, d3, f, ns, p, c;
        for (int i = 0; i < 8; i++) nw[i] = -1000000;
        for (int s = 0; s < 8; s++) begin
            for (int u = 0; u < 2; u++) begin
                d1 = (s >> 2) & 1;
                d2 = (s >> 1) & 1;
                d3 = s & 1;
                f  = u ^ d2 ^ d3;
                ns = 4 * f + 2 * d1 + d2;
                p  = f ^ d1 ^ d3;
                c  = m_alpha[s] + (u != 0 ? ls : 0) + (p != 0 ? lp : 0);
                if (c > nw[ns]) nw[ns] = c;
            end
        end
        mx = nw[0];
        for (int i = 1; i < 8; i++) if (nw[i] > mx) mx = nw[i];
        for (int i = 0; i < 8; i++) begin
            m_alpha[i] = nw[i] - mx;
            if (m_alpha[i] < -32768) m_alpha[i] = -32768;
        end
    endtask

    task automatic fill_const(input int ls, input int lp);
        for (int i = 0; i < 256; i++) begin
            sys_mem[i] = 16'(ls);
            par_mem[i] = 16'(lp);
        end
    endtask

    task automatic fill_random(input int span);
        for (int i = 0; i < 256; i++) begin
            if (span == 0) begin
                sys_mem[i] = 16'($urandom);
                par_mem[i] = 16'($urandom);
            end else begin
                sys_mem[i] = 16'(int'($urandom_range(2 * span, 0)) - span);
                par_mem[i] = 16'(int'($urandom_range(2 * span, 0)) - span);
            end
        end
    endtask

    // Runs one block of n steps; pulse_at > 0 pulses start again in that cycle.
    task automatic run_block(input int n, input int pulse_at);
        exp_t e;
        logic [7:0][15:0] fin;
        int done_cyc, busy_cyc;
        model_init();
        exp_q.delete();
        for (int k = 0; k < n; k++) begin
            e.addr = 8'(k);
            for (int i = 0; i < 8; i++) e.v[i] = m_alpha[i][15:0];
            exp_q.push_back(e);
            model_step(sys_mem[k], par_mem[k]);
        end
        for (int i = 0; i < 8; i++) fin[i] = m_alpha[i][15:0];

        @(negedge clk);
        count_main = 8'(n);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        count_main = 8'($urandom);
        done_cyc = -1;
        busy_cyc = 0;
        for (int cyc = 1; cyc <= 2 * n + 6 && done_cyc < 0; cyc++) begin
            @(negedge clk);
            if (busy) busy_cyc++;
            if (w_r_f) begin
                chk_cnt++;
                if (exp_q.size() == 0) begin
                    $display("FAIL extra_write n=%0d cyc=%0d got addr=%0d", n, cyc, fa_addr);
                end else begin
                    e = exp_q.pop_front();
                    if ({fa_addr, rd_addr, got} !== {e.addr, e.addr, e.v})
                        $display("FAIL write n=%0d cyc=%0d got fa=%0d rd=%0d v=%h exp addr=%0d v=%h",
                                 n, cyc, fa_addr, rd_addr, got, e.addr, e.v);
                    else pass_cnt++;
                end
            end
            if (done_fwd) done_cyc = cyc;
            start = (cyc == pulse_at);
            if (cyc == pulse_at) count_main = 8'($urandom_range(255, 1));
        end
        start = 1'b0;

        chk_cnt++;
        if (done_cyc !== 2 * n + 1)
            $display("FAIL done_timing n=%0d got cycle %0d exp %0d", n, done_cyc, 2 * n + 1);
        else pass_cnt++;
        chk_cnt++;
        if (busy_cyc !== 2 * n)
            $display("FAIL busy_cycles n=%0d got %0d exp %0d", n, busy_cyc, 2 * n);
        else pass_cnt++;
        chk_cnt++;
        if (exp_q.size() !== 0)
            $display("FAIL missing_writes n=%0d got %0d left exp 0", n, exp_q.size());
        else pass_cnt++;
        chk_cnt++;
        if (got !== fin)
            $display("FAIL final_alpha n=%0d got %h exp %h", n, got, fin);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        start = 1'b0;
        count_main = 8'd0;
        fill_const(0, 0);
        #12;
        chk_cnt++;
        if ({rd_addr, fa_addr, w_r_f, busy, done_fwd, got} !== '0)
            $display("FAIL reset_state got %h exp 0", {rd_addr, fa_addr, w_r_f, busy, done_fwd, got});
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk_cnt++;
        if ({rd_addr, fa_addr, w_r_f, busy, done_fwd, got} !== '0)
            $display("FAIL idle_state got %h exp 0", {rd_addr, fa_addr, w_r_f, busy, done_fwd, got});
        else pass_cnt++;
    endtask

    task automatic test_n0();
        run_block(0, 0);
    endtask

    task automatic test_n1();
        fill_const(0, 0);
        sys_mem[0] = 16'sd100;
        par_mem[0] = 16'sd50;
        run_block(1, 0);
        chk_cnt++;
        if (a4 !== 16'sd0 || a0 !== -16'sd150 || a1 > -16'sd16384 || a2 > -16'sd16384 ||
            a3 > -16'sd16384 || a5 > -16'sd16384 || a6 > -16'sd16384 || a7 > -16'sd16384)
            $display("FAIL n1_values got a0=%0d a4=%0d others=%0d,%0d,%0d,%0d,%0d,%0d exp a0=-150 a4=0 others<=-16384",
                     a0, a4, a1, a2, a3, a5, a6, a7);
        else pass_cnt++;
    endtask

    task automatic test_n4_zero();
        fill_const(0, 0);
        run_block(4, 0);
        chk_cnt++;
        if (got !== '0) $display("FAIL n4_zero got %h exp all 0", got);
        else pass_cnt++;
    endtask

    task automatic test_saturation();
        logic signed [15:0] mx;
        fill_const(-32768, -32768);
        run_block(16, 0);
        mx = a0;
        if (a1 > mx) mx = a1;
        if (a2 > mx) mx = a2;
        if (a3 > mx) mx = a3;
        if (a4 > mx) mx = a4;
        if (a5 > mx) mx = a5;
        if (a6 > mx) mx = a6;
        if (a7 > mx) mx = a7;
        chk_cnt++;
        if (mx !== 16'sd0) $display("FAIL sat_max got %0d exp 0", mx);
        else pass_cnt++;
    endtask

    task automatic test_start_ignored();
        fill_random(3000);
        run_block(10, 7);
    endtask

    task automatic test_reset_mid();
        int bad;
        fill_random(0);
        @(negedge clk);
        count_main = 8'd20;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk_cnt++;
        if ({rd_addr, fa_addr, w_r_f, busy, done_fwd, got} !== '0)
            $display("FAIL reset_mid got %h exp 0", {rd_addr, fa_addr, w_r_f, busy, done_fwd, got});
        else pass_cnt++;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (w_r_f || busy || done_fwd) bad++;
        end
        chk_cnt++;
        if (bad !== 0) $display("FAIL after_reset_activity got %0d active cycles exp 0", bad);
        else pass_cnt++;
        run_block(12, 0);
    endtask

    task automatic test_random();
        for (int t = 0; t < 4; t++) begin
            fill_random((t == 1) ? 500 : 0);
            run_block((t == 3) ? 255 : int'($urandom_range(255, 1)), 0);
        end
    endtask

    initial begin
        test_reset();
        test_n0();
        test_n1();
        test_n4_zero();
        test_saturation();
        test_start_ignored();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
